// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller: owns the PC, runs a req/ack memory port,
// latches the returned word into the instruction register and hands it to execute.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  output logic             oMemReq,
  output logic [31:0]      oMemAddr,
  input  logic             iMemAck,
  input  logic [31:0]      iMemData,
  input  logic             iMemErr,
  output logic [31:0]      oIR,
  output logic [31:0]      oInsPC,
  output logic             oInsValid,
  input  logic             iInsReady,
  input  logic             iRedirect,
  input  logic [31:0]      iRedirectPC,
  output logic             oFault,
  output logic [1:0]       oFaultCause,
  output logic [31:0]      oFaultAddr,
  output logic [CNT_W-1:0] oInsCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  localparam logic [31:0] NOP_INS     = 32'h0000_0013;
  localparam logic [1:0]  CAUSE_NONE  = 2'd0;
  localparam logic [1:0]  CAUSE_ALIGN = 2'd1;
  localparam logic [1:0]  CAUSE_BUS   = 2'd2;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        ins_pc_q, ins_pc_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [1:0]         cause_q, cause_d;
  logic [31:0]        fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redir_bad;

  assign redir_bad = |iRedirectPC[1:0];

  // NOTE: every next-state signal gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ins_pc_d     = ins_pc_q;
    tgt_d        = tgt_q;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (iMemAck && iRedirect) begin
          if (redir_bad) begin
            state_d      = S_FAULT;
            cause_d      = CAUSE_ALIGN;
            fault_addr_d = iRedirectPC;
          end else begin
            pc_d = iRedirectPC;
          end
        end else if (iMemAck && iMemErr) begin
          state_d      = S_FAULT;
          cause_d      = CAUSE_BUS;
          fault_addr_d = pc_q;
        end else if (iMemAck) begin
          ir_d     = iMemData;
          ins_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_HOLD;
        end else if (iRedirect) begin
          if (redir_bad) begin
            state_d      = S_FAULT;
            cause_d      = CAUSE_ALIGN;
            fault_addr_d = iRedirectPC;
          end else begin
            tgt_d   = iRedirectPC;
            state_d = S_DRAIN;
          end
        end
      end

      // The in-flight request must complete before the new target can be fetched.
      S_DRAIN: begin
        if (iRedirect && redir_bad) begin
          state_d      = S_FAULT;
          cause_d      = CAUSE_ALIGN;
          fault_addr_d = iRedirectPC;
        end else begin
          if (iRedirect) tgt_d = iRedirectPC;
          if (iMemAck) begin
            pc_d    = iRedirect ? iRedirectPC : tgt_q;
            state_d = S_FETCH;
          end
        end
      end

      S_HOLD: begin
        if (iInsReady) cnt_d = cnt_q + 1'b1;
        if (iRedirect) begin
          if (redir_bad) begin
            state_d      = S_FAULT;
            cause_d      = CAUSE_ALIGN;
            fault_addr_d = iRedirectPC;
          end else begin
            pc_d    = iRedirectPC;
            state_d = S_FETCH;
          end
        end else if (iInsReady) begin
          state_d = S_FETCH;
        end
      end

      S_FAULT: state_d = S_FAULT;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= NOP_INS;
      ins_pc_q     <= 32'd0;
      tgt_q        <= 32'd0;
      cause_q      <= CAUSE_NONE;
      fault_addr_q <= 32'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ins_pc_q     <= ins_pc_d;
      tgt_q        <= tgt_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  // pc only moves on the cycle a request completes, so it is the stable fetch address.
  assign oMemReq     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign oMemAddr    = pc_q;
  assign oIR         = ir_q;
  assign oInsPC      = ins_pc_q;
  assign oInsValid   = (state_q == S_HOLD);
  assign oFault      = (state_q == S_FAULT);
  assign oFaultCause = cause_q;
  assign oFaultAddr  = fault_addr_q;
  assign oInsCount   = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a default instance for the main scenarios and a
// second instance at the top of the address space with a narrow counter for wrap cases.
module tb_fetch_sequencer;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;

  logic        oMemReq, oInsValid, oFault;
  logic [31:0] oMemAddr, oIR, oInsPC, oFaultAddr, oInsCount;
  logic [1:0]  oFaultCause;
  logic        iMemAck = 1'b0, iMemErr = 1'b0, iInsReady = 1'b0, iRedirect = 1'b0;
  logic [31:0] iMemData = 32'd0, iRedirectPC = 32'd0;

  logic        req2, valid2, fault2;
  logic [31:0] addr2, ir2, inspc2, faddr2;
  logic [1:0]  cause2, cnt2;
  logic        ack2 = 1'b0, ready2 = 1'b0;
  logic [31:0] data2 = 32'd0;

  int checks = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  fetch_sequencer dut (
    .iClk(iClk), .iRst(iRst),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr),
    .iMemAck(iMemAck), .iMemData(iMemData), .iMemErr(iMemErr),
    .oIR(oIR), .oInsPC(oInsPC), .oInsValid(oInsValid), .iInsReady(iInsReady),
    .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
    .oFault(oFault), .oFaultCause(oFaultCause), .oFaultAddr(oFaultAddr),
    .oInsCount(oInsCount)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_wrap (
    .iClk(iClk), .iRst(iRst),
    .oMemReq(req2), .oMemAddr(addr2),
    .iMemAck(ack2), .iMemData(data2), .iMemErr(1'b0),
    .oIR(ir2), .oInsPC(inspc2), .oInsValid(valid2), .iInsReady(ready2),
    .iRedirect(1'b0), .iRedirectPC(32'd0),
    .oFault(fault2), .oFaultCause(cause2), .oFaultAddr(faddr2),
    .oInsCount(cnt2)
  );

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    cmp("rst_req",   {31'd0, oMemReq},     32'd0);
    cmp("rst_addr",  oMemAddr,             32'd0);
    cmp("rst_ir",    oIR,                  32'h0000_0013);
    cmp("rst_inspc", oInsPC,               32'd0);
    cmp("rst_valid", {31'd0, oInsValid},   32'd0);
    cmp("rst_fault", {31'd0, oFault},      32'd0);
    cmp("rst_cause", {30'd0, oFaultCause}, 32'd0);
    cmp("rst_faddr", oFaultAddr,           32'd0);
    cmp("rst_cnt",   oInsCount,            32'd0);
    iRst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    @(negedge iClk);
    cmp("t1_req",   {31'd0, oMemReq},   32'd1);
    cmp("t1_addr",  oMemAddr,           32'd0);
    @(negedge iClk);
    cmp("t1_wait_req", {31'd0, oMemReq}, 32'd1);
    cmp("t1_wait_vld", {31'd0, oInsValid}, 32'd0);
    @(negedge iClk);
    iMemAck = 1'b1; iMemData = 32'h0050_0093;
    @(negedge iClk);
    iMemAck = 1'b0;
    cmp("t1_valid", {31'd0, oInsValid}, 32'd1);
    cmp("t1_ir",    oIR,                32'h0050_0093);
    cmp("t1_inspc", oInsPC,             32'd0);
    cmp("t1_hold_req", {31'd0, oMemReq}, 32'd0);
    iInsReady = 1'b1;
    @(negedge iClk);
    iInsReady = 1'b0;
    cmp("t1_next_addr", oMemAddr,           32'd4);
    cmp("t1_next_req",  {31'd0, oMemReq},   32'd1);
    cmp("t1_cnt",       oInsCount,          32'd1);
    cmp("t1_vld_drop",  {31'd0, oInsValid}, 32'd0);
  endtask

  task automatic test_redirect_drain();
    iRedirect = 1'b1; iRedirectPC = 32'h100;
    @(negedge iClk);
    iRedirect = 1'b0;
    cmp("t2_drain_req",  {31'd0, oMemReq}, 32'd1);
    cmp("t2_drain_addr", oMemAddr,         32'd4);
    @(negedge iClk);
    cmp("t2_drain_addr2", oMemAddr,           32'd4);
    cmp("t2_drain_vld",   {31'd0, oInsValid}, 32'd0);
    @(negedge iClk);
    iMemAck = 1'b1; iMemData = 32'hDEAD_BEEF;
    @(negedge iClk);
    iMemAck = 1'b0;
    cmp("t2_new_addr", oMemAddr,           32'h100);
    cmp("t2_new_req",  {31'd0, oMemReq},   32'd1);
    cmp("t2_no_vld",   {31'd0, oInsValid}, 32'd0);
    cmp("t2_ir_kept",  oIR,                32'h0050_0093);
  endtask

  task automatic test_ready_and_redirect();
    // ack and redirect together: fetched word is discarded, refetch from 8
    iMemAck = 1'b1; iMemData = 32'h0000_0BAD; iRedirect = 1'b1; iRedirectPC = 32'h8;
    @(negedge iClk);
    iMemAck = 1'b0; iRedirect = 1'b0;
    cmp("t3_refetch_addr", oMemAddr,           32'h8);
    cmp("t3_refetch_vld",  {31'd0, oInsValid}, 32'd0);
    iMemAck = 1'b1; iMemData = 32'h0020_8133;
    @(negedge iClk);
    iMemAck = 1'b0;
    cmp("t3_valid", {31'd0, oInsValid}, 32'd1);
    cmp("t3_inspc", oInsPC,             32'h8);
    cmp("t3_ir",    oIR,                32'h0020_8133);
    iInsReady = 1'b1; iRedirect = 1'b1; iRedirectPC = 32'h40;
    @(negedge iClk);
    iInsReady = 1'b0; iRedirect = 1'b0;
    cmp("t3_cnt",   oInsCount,          32'd2);
    cmp("t3_addr",  oMemAddr,           32'h40);
    cmp("t3_req",   {31'd0, oMemReq},   32'd1);
    cmp("t3_vld0",  {31'd0, oInsValid}, 32'd0);
  endtask

  task automatic test_misaligned_fault();
    iRedirect = 1'b1; iRedirectPC = 32'h102;
    @(negedge iClk);
    iRedirect = 1'b0;
    cmp("t4_fault", {31'd0, oFault},      32'd1);
    cmp("t4_cause", {30'd0, oFaultCause}, 32'd1);
    cmp("t4_faddr", oFaultAddr,           32'h102);
    cmp("t4_req",   {31'd0, oMemReq},     32'd0);
    for (int i = 0; i < 4; i++) begin
      iMemAck = 1'b1; iInsReady = 1'b1; iRedirect = 1'b1; iRedirectPC = 32'h200;
      @(negedge iClk);
      cmp("t4_stuck_req",   {31'd0, oMemReq}, 32'd0);
      cmp("t4_stuck_faddr", oFaultAddr,       32'h102);
      cmp("t4_stuck_cnt",   oInsCount,        32'd2);
    end
    iMemAck = 1'b0; iInsReady = 1'b0; iRedirect = 1'b0;
  endtask

  task automatic test_bus_error_and_reset();
    iRst = 1'b1;
    @(negedge iClk);
    cmp("t5_rst_fault", {31'd0, oFault}, 32'd0);
    cmp("t5_rst_cnt",   oInsCount,       32'd0);
    iRst = 1'b0;
    @(negedge iClk);
    iMemAck = 1'b1; iRedirect = 1'b1; iRedirectPC = 32'hC;
    @(negedge iClk);
    iRedirect = 1'b0;
    cmp("t5_addr_c", oMemAddr, 32'hC);
    iMemErr = 1'b1;
    @(negedge iClk);
    iMemAck = 1'b0; iMemErr = 1'b0;
    cmp("t5_fault", {31'd0, oFault},      32'd1);
    cmp("t5_cause", {30'd0, oFaultCause}, 32'd2);
    cmp("t5_faddr", oFaultAddr,           32'hC);
    cmp("t5_req",   {31'd0, oMemReq},     32'd0);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    iRedirect = 1'b1; iRedirectPC = 32'h20;
    @(negedge iClk);
    iRedirect = 1'b0;
    cmp("t5_drain_addr", oMemAddr, 32'd0);
    iRst = 1'b1;
    #1;
    cmp("t5_async_req",   {31'd0, oMemReq},     32'd0);
    cmp("t5_async_addr",  oMemAddr,             32'd0);
    cmp("t5_async_ir",    oIR,                  32'h0000_0013);
    cmp("t5_async_cause", {30'd0, oFaultCause}, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    cmp("t5_first_req",  {31'd0, oMemReq}, 32'd1);
    cmp("t5_first_addr", oMemAddr,         32'd0);
    iMemAck = 1'b1; iMemData = 32'h0000_0013;
    @(negedge iClk);
    iMemAck = 1'b0;
    cmp("t5_first_vld",   {31'd0, oInsValid}, 32'd1);
    cmp("t5_first_inspc", oInsPC,             32'd0);
  endtask

  task automatic test_pc_wrap();
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    cmp("t6_req",  {31'd0, req2}, 32'd1);
    cmp("t6_addr", addr2,         32'hFFFF_FFFC);
    ack2 = 1'b1; data2 = 32'h0010_0113;
    @(negedge iClk);
    ack2 = 1'b0;
    cmp("t6_valid", {31'd0, valid2}, 32'd1);
    cmp("t6_inspc", inspc2,          32'hFFFF_FFFC);
    ready2 = 1'b1;
    @(negedge iClk);
    ready2 = 1'b0;
    cmp("t6_wrap_addr", addr2,        32'd0);
    cmp("t6_cnt",       {30'd0, cnt2}, 32'd1);
  endtask

  task automatic test_back_to_back();
    // zero-wait ack and immediate ready; 2-bit counter wraps after four instructions
    for (int i = 0; i < 3; i++) begin
      ack2 = 1'b1; data2 = 32'h100 + 32'(i);
      @(negedge iClk);
      ack2 = 1'b0;
      cmp("b2b_inspc", inspc2, 32'(4 * i));
      cmp("b2b_ir",    ir2,    32'h100 + 32'(i));
      ready2 = 1'b1;
      @(negedge iClk);
      ready2 = 1'b0;
    end
    cmp("b2b_addr",     addr2,         32'hC);
    cmp("b2b_cnt_wrap", {30'd0, cnt2}, 32'd0);
    cmp("b2b_no_fault", {31'd0, fault2} | {30'd0, cause2} | faddr2, 32'd0);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_redirect_drain();
    test_ready_and_redirect();
    test_misaligned_fault();
    test_bus_error_and_reset();
    test_pc_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
